// File: rtl/async_oneway_receiver_pkg.sv
// Shared packet geometry and receiver state type for the one-way packet link.
// Optional feature macro used by the receiver: RX_FRAME_CHECK_EN.
package async_oneway_receiver_pkg;

    localparam int MESSAGE_SIZE = 20;
    localparam int PKT_W        = 6;
    localparam int NPKT         = (MESSAGE_SIZE + PKT_W - 1) / PKT_W;
    localparam int BUF_W        = NPKT * PKT_W;
    localparam int CNT_W        = $clog2(NPKT + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RECV     = 2'd1,
        S_WAIT_END = 2'd2
    } rx_state_e;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit synchronizer with synchronous active-low reset.
module cdc_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/async_oneway_receiver.sv
// Reassembles LSB-first 6-bit packets from a foreign clock domain into datagrams.
// RX_FRAME_CHECK_EN: completion waits for the ctrl fall and malformed frames raise frame_err.
module async_oneway_receiver
    import async_oneway_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk_recv,
    input  logic                    rst_n,
    input  logic [PKT_W-1:0]        packet_in,
    input  logic                    packet_pulse_in,
    input  logic                    transmit_ctrl_in,
    output logic [MESSAGE_SIZE-1:0] datagram_out,
    output logic                    datagram_valid,
    output logic                    busy,
    output logic                    frame_err
);

    rx_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [BUF_W-1:0] asm_buf;
    logic [BUF_W-1:0] buf_next;
    logic             pkt_s;
    logic             pkt_dly;
    logic             pkt_evt;
    logic             ctrl_s;
    logic             last_pkt;

    cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pkt (
        .clk   (clk_recv),
        .rst_n (rst_n),
        .d     (packet_pulse_in),
        .q     (pkt_s)
    );

    cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ctrl (
        .clk   (clk_recv),
        .rst_n (rst_n),
        .d     (transmit_ctrl_in),
        .q     (ctrl_s)
    );

    if (NPKT == 1) begin : g_one_pkt
        assign buf_next = packet_in;
    end else begin : g_shift_pkt
        assign buf_next = {packet_in, asm_buf[BUF_W-1:PKT_W]};
    end

    assign pkt_evt  = pkt_s & ~pkt_dly;
    assign last_pkt = (cnt == CNT_W'(NPKT - 1));
    assign busy     = (state != S_IDLE);

`ifdef RX_FRAME_CHECK_EN
    logic ctrl_dly;
    logic ctrl_fall;

    assign ctrl_fall = ~ctrl_s & ctrl_dly;

    always_ff @(posedge clk_recv) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            asm_buf        <= '0;
            datagram_out   <= '0;
            datagram_valid <= 1'b0;
            frame_err      <= 1'b0;
            pkt_dly        <= 1'b0;
            ctrl_dly       <= 1'b0;
        end else begin
            datagram_valid <= 1'b0;
            frame_err      <= 1'b0;
            pkt_dly        <= pkt_s;
            ctrl_dly       <= ctrl_s;
            case (state)
                S_IDLE, S_RECV: begin
                    // Frame window closed before all packets arrived: short frame.
                    if (state == S_RECV && ctrl_fall) begin
                        frame_err <= 1'b1;
                        cnt       <= '0;
                        state     <= S_IDLE;
                    end else if (pkt_evt) begin
                        asm_buf <= buf_next;
                        if (last_pkt) begin
                            cnt   <= CNT_W'(NPKT);
                            state <= S_WAIT_END;
                        end else begin
                            cnt   <= cnt + CNT_W'(1);
                            state <= S_RECV;
                        end
                    end
                end
                S_WAIT_END: begin
                    if (pkt_evt) begin
                        frame_err <= 1'b1;
                        cnt       <= '0;
                        state     <= S_IDLE;
                    end else if (ctrl_fall) begin
                        datagram_out   <= asm_buf[MESSAGE_SIZE-1:0];
                        datagram_valid <= 1'b1;
                        cnt            <= '0;
                        state          <= S_IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
`else
    logic             unused_ctrl;
    logic [PKT_W-1:0] unused_buf_lsb;

    // Completion is purely count-based; ctrl only feeds its synchronizer.
    assign unused_ctrl    = ctrl_s;
    assign unused_buf_lsb = asm_buf[PKT_W-1:0];
    assign frame_err      = 1'b0;

    always_ff @(posedge clk_recv) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            asm_buf        <= '0;
            datagram_out   <= '0;
            datagram_valid <= 1'b0;
            pkt_dly        <= 1'b0;
        end else begin
            datagram_valid <= 1'b0;
            pkt_dly        <= pkt_s;
            case (state)
                S_IDLE, S_RECV: begin
                    if (pkt_evt) begin
                        asm_buf <= buf_next;
                        if (last_pkt) begin
                            datagram_out   <= buf_next[MESSAGE_SIZE-1:0];
                            datagram_valid <= 1'b1;
                            cnt            <= '0;
                            state          <= S_IDLE;
                        end else begin
                            cnt   <= cnt + CNT_W'(1);
                            state <= S_RECV;
                        end
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
`endif

endmodule
